// File: rtl/hist_eq_output_pipe.sv
// Histogram-equalisation output pipe: fills a 256-entry LUT from the CDF
// memory, then streams pixel words through the LUT into the output memory.
// Optional macro HIST_EQ_ROUND_EN selects round-half-up instead of truncation
// for the LUT division.
module hist_eq_output_pipe #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned NUM_WORDS = 4096,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned CDF_W     = 20
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CDF_W-1:0]     cdf_min,
  input  logic [CDF_W-1:0]     divisor,
  input  logic                 output_base_offset,
  output logic [7:0]           cdf_addr,
  input  logic [CDF_W-1:0]     cdf_rdata,
  output logic [ADDR_W-1:0]    pix_addr,
  input  logic [LANES*8-1:0]   pix_rdata,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LANES*8-1:0]   wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NUM_W = CDF_W + 8;
  localparam int unsigned SUM_W = NUM_W + 1;
  localparam int unsigned DW    = LANES * 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BANK_OFS  = ADDR_W'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, LUT_FILL, STREAM, DRAIN} state_t;

  state_t              state_q;
  logic                busy_q, done_q;
  logic [7:0]          cdf_addr_q;
  logic                cdf_req_q;   // a CDF address is being presented
  logic                cdf_dv_q;    // cdf_rdata is valid for lut_idx_q
  logic [7:0]          lut_idx_q;
  logic [ADDR_W-1:0]   pix_addr_q;
  logic                pix_req_q;   // a pixel address is being presented
  logic                pix_dv_q;    // pix_rdata is valid for widx_q
  logic [ADDR_W-1:0]   widx_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DW-1:0]       wr_data_q;
  logic [CDF_W-1:0]    cdf_min_q, div_q;
  logic                obase_q;
  logic [7:0]          lut_q [256];

  logic [CDF_W-1:0]    diff_d;
  logic [NUM_W-1:0]    num_d;
  logic [SUM_W-1:0]    quot_d;
  logic [7:0]          lut_entry_d;
  logic [DW-1:0]       wr_data_d;
  logic [ADDR_W-1:0]   wr_addr_d;

  // LUT entry from the CDF word: scale, divide, saturate; zero divisor maps to 255
  always_comb begin
    diff_d      = '0;
    num_d       = '0;
    quot_d      = '0;
    lut_entry_d = 8'hFF;
    if (cdf_rdata >= cdf_min_q) diff_d = cdf_rdata - cdf_min_q;
    num_d = NUM_W'(diff_d) * NUM_W'(255);
    if (div_q != '0) begin
`ifdef HIST_EQ_ROUND_EN
      quot_d = (SUM_W'(num_d) + SUM_W'(div_q >> 1)) / SUM_W'(div_q);
`else
      quot_d = SUM_W'(num_d) / SUM_W'(div_q);
`endif
      lut_entry_d = (quot_d > SUM_W'(255)) ? 8'hFF : quot_d[7:0];
    end
  end

  // Map every lane through the LUT and form the banked write address
  always_comb begin
    wr_data_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      wr_data_d[8*k +: 8] = lut_q[pix_rdata[8*k +: 8]];
    end
    wr_addr_d = widx_q + (obase_q ? BANK_OFS : '0);
  end

  // LUT storage; contents are not meaningful until a fill completes
  always_ff @(posedge clock) begin
    if (cdf_dv_q) lut_q[lut_idx_q] <= lut_entry_d;
  end

  // Control FSM and the address/data pipelines
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cdf_addr_q <= '0;
      cdf_req_q  <= 1'b0;
      cdf_dv_q   <= 1'b0;
      lut_idx_q  <= '0;
      pix_addr_q <= '0;
      pix_req_q  <= 1'b0;
      pix_dv_q   <= 1'b0;
      widx_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cdf_min_q  <= '0;
      div_q      <= '0;
      obase_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cdf_dv_q  <= cdf_req_q;
      lut_idx_q <= cdf_addr_q;
      pix_dv_q  <= pix_req_q;
      widx_q    <= pix_addr_q;
      wr_en_q   <= pix_dv_q;
      if (pix_dv_q) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LUT_FILL;
            busy_q     <= 1'b1;
            cdf_addr_q <= '0;
            cdf_req_q  <= 1'b1;
            cdf_min_q  <= cdf_min;
            div_q      <= divisor;
            obase_q    <= output_base_offset;
          end
        end
        LUT_FILL: begin
          if (cdf_req_q) begin
            if (cdf_addr_q == 8'hFF) cdf_req_q <= 1'b0;
            else                     cdf_addr_q <= cdf_addr_q + 8'd1;
          end
          // Last LUT entry is written on this edge; streaming follows directly
          if (cdf_dv_q && (lut_idx_q == 8'hFF)) begin
            state_q    <= STREAM;
            pix_addr_q <= '0;
            pix_req_q  <= 1'b1;
          end
        end
        STREAM: begin
          if (pix_addr_q == LAST_ADDR) begin
            state_q   <= DRAIN;
            pix_req_q <= 1'b0;
          end else begin
            pix_addr_q <= pix_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Final write is on the port now and nothing is left in flight
          if (!pix_dv_q && wr_en_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cdf_addr = cdf_addr_q;
  assign pix_addr = pix_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hist_eq_output_pipe.sv
// Directed testbench for hist_eq_output_pipe (NUM_WORDS = 4, LANES = 16).
module tb_hist_eq_output_pipe;

  localparam int unsigned LANES     = 16;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned CDF_W     = 20;
  localparam int unsigned DW        = LANES * 8;
  localparam int          LAT       = 263;   // 256 + 1 + 4 + 2

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [CDF_W-1:0]  cdf_min, divisor;
  logic              output_base_offset;
  logic [7:0]        cdf_addr;
  logic [CDF_W-1:0]  cdf_rdata;
  logic [ADDR_W-1:0] pix_addr;
  logic [DW-1:0]     pix_rdata;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic              busy, done;

  always #5 clock = ~clock;

  hist_eq_output_pipe #(
    .LANES(LANES), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .CDF_W(CDF_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cdf_min(cdf_min), .divisor(divisor), .output_base_offset(output_base_offset),
    .cdf_addr(cdf_addr), .cdf_rdata(cdf_rdata),
    .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // Synchronous-read memory models: data valid the cycle after the address
  logic [CDF_W-1:0] cdf_mem [256];
  logic [DW-1:0]    pix_mem [4];
  always @(posedge clock) begin
    cdf_rdata <= cdf_mem[cdf_addr];
    pix_rdata <= (pix_addr < ADDR_W'(4)) ? pix_mem[pix_addr[1:0]] : '0;
  end

  int checks = 0;
  int errors = 0;

  int                wr_cyc [8];
  logic [ADDR_W-1:0] wr_a   [8];
  logic [DW-1:0]     wr_d   [8];
  logic [DW-1:0]     exp_d  [4];
  int n_wr, n_done, done_cyc, seq_err, busy_err;

  // Start one run and record what the DUT does over 300 cycles.
  // repulse >= 0 re-asserts start (with different constants) at that cycle.
  task automatic do_run(input logic obase, input int repulse);
    int cyc;
    n_wr = 0; n_done = 0; done_cyc = -1; seq_err = 0; busy_err = 0;
    for (int i = 0; i < 8; i++) begin
      wr_cyc[i] = -1; wr_a[i] = '1; wr_d[i] = '0;
    end
    @(negedge clock);
    output_base_offset = obase;
    start = 1'b1;
    @(posedge clock);
    cyc = 0;
    @(negedge clock);
    start = 1'b0;
    for (int it = 0; it < 300; it++) begin
      if (it > 0) begin
        @(posedge clock);
        cyc++;
        @(negedge clock);
      end
      if (cyc <= 255 && cdf_addr !== 8'(cyc)) seq_err++;
      if (wr_en === 1'b1) begin
        if (n_wr < 8) begin
          wr_cyc[n_wr] = cyc; wr_a[n_wr] = wr_addr; wr_d[n_wr] = wr_data;
        end
        n_wr++;
      end
      if (done === 1'b1) begin
        if (n_done == 0) done_cyc = cyc;
        n_done++;
      end
      if (cyc < LAT && busy !== 1'b1) busy_err++;
      if (cyc >= LAT && busy !== 1'b0) busy_err++;
      if (cyc == repulse) begin
        start = 1'b1; cdf_min = '0; divisor = 20'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; cdf_min = '0; divisor = '0; output_base_offset = 1'b0;
    for (int i = 0; i < 256; i++) cdf_mem[i] = '0;
    for (int i = 0; i < 4; i++) pix_mem[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (cdf_addr !== 8'h0) begin errors++; $display("FAIL reset_cdf_addr: got %h expected 0", cdf_addr); end
    checks++; if (pix_addr !== '0)   begin errors++; $display("FAIL reset_pix_addr: got %h expected 0", pix_addr); end
    checks++; if (wr_addr !== '0)    begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== '0)    begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // cdf[i] = i+1, cdf_min = 1, divisor = 63
  task automatic load_ramp();
    logic [DW-1:0] w0, e0;
    for (int i = 0; i < 256; i++) cdf_mem[i] = CDF_W'(i + 1);
    for (int k = 0; k < int'(LANES); k++) begin
      case (k % 3)
        0:       begin w0[8*k +: 8] = 8'h3F; e0[8*k +: 8] = 8'hFF; end
`ifdef HIST_EQ_ROUND_EN
        1:       begin w0[8*k +: 8] = 8'h20; e0[8*k +: 8] = 8'h82; end
`else
        1:       begin w0[8*k +: 8] = 8'h20; e0[8*k +: 8] = 8'h81; end
`endif
        default: begin w0[8*k +: 8] = 8'h00; e0[8*k +: 8] = 8'h00; end
      endcase
    end
    pix_mem[0] = w0;            exp_d[0] = e0;
    pix_mem[1] = {16{8'h01}};   exp_d[1] = {16{8'h04}};
    pix_mem[2] = {16{8'h10}};
`ifdef HIST_EQ_ROUND_EN
    exp_d[2] = {16{8'h41}};
`else
    exp_d[2] = {16{8'h40}};
`endif
    pix_mem[3] = {16{8'hFF}};   exp_d[3] = {16{8'hFF}};
    cdf_min = 20'd1;
    divisor = 20'd63;
  endtask

  task automatic test_ramp();
    load_ramp();
    do_run(1'b0, -1);
    checks++; if (seq_err != 0)   begin errors++; $display("FAIL ramp_cdf_seq: got %0d bad addresses expected 0", seq_err); end
    checks++; if (done_cyc != LAT) begin errors++; $display("FAIL ramp_latency: got %0d expected %0d", done_cyc, LAT); end
    checks++; if (n_done != 1)    begin errors++; $display("FAIL ramp_done_count: got %0d expected 1", n_done); end
    checks++; if (n_wr != 4)      begin errors++; $display("FAIL ramp_wr_count: got %0d expected 4", n_wr); end
    checks++; if (busy_err != 0)  begin errors++; $display("FAIL ramp_busy: got %0d bad cycles expected 0", busy_err); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_cyc[i] != 259 + i) begin errors++; $display("FAIL ramp_wr_cycle[%0d]: got %0d expected %0d", i, wr_cyc[i], 259 + i); end
      checks++; if (wr_a[i] !== ADDR_W'(i)) begin errors++; $display("FAIL ramp_wr_addr[%0d]: got %0d expected %0d", i, wr_a[i], i); end
      checks++; if (wr_d[i] !== exp_d[i])   begin errors++; $display("FAIL ramp_wr_data[%0d]: got %h expected %h", i, wr_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_restart();
    load_ramp();
    do_run(1'b0, 50);
    checks++; if (seq_err != 0)    begin errors++; $display("FAIL restart_cdf_seq: got %0d bad addresses expected 0", seq_err); end
    checks++; if (n_done != 1)     begin errors++; $display("FAIL restart_done_count: got %0d expected 1", n_done); end
    checks++; if (done_cyc != LAT) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", done_cyc, LAT); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_d[i] !== exp_d[i]) begin errors++; $display("FAIL restart_wr_data[%0d]: got %h expected %h", i, wr_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad;
    load_ramp();
    @(negedge clock);
    output_base_offset = 1'b0;
    start = 1'b1;
    @(posedge clock);
    cyc = 0;
    @(negedge clock);
    start = 1'b0;
    for (int it = 0; it < 300; it++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (cyc > 257 && busy === 1'b1 && pix_addr === ADDR_W'(2)) break;
    end
    checks++; if (cyc != 259) begin errors++; $display("FAIL midreset_reach_word2: got cycle %0d expected 259", cyc); end
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en: got %b expected 0", wr_en); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
    load_ramp();
    do_run(1'b0, -1);
    checks++; if (done_cyc != LAT) begin errors++; $display("FAIL midreset_rerun_latency: got %0d expected %0d", done_cyc, LAT); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_d[i] !== exp_d[i]) begin errors++; $display("FAIL midreset_rerun_data[%0d]: got %h expected %h", i, wr_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 256; i++) cdf_mem[i] = CDF_W'(i * 3);
    pix_mem[0] = {16{8'h00}};
    pix_mem[1] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    pix_mem[2] = {16{8'h80}};
    pix_mem[3] = {8{8'h7F, 8'h01}};
    cdf_min = '0;
    divisor = '0;
    do_run(1'b0, -1);
    checks++; if (n_wr != 4) begin errors++; $display("FAIL divzero_wr_count: got %0d expected 4", n_wr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_d[i] !== {16{8'hFF}}) begin errors++; $display("FAIL divzero_wr_data[%0d]: got %h expected all ff", i, wr_d[i]); end
    end
  endtask

  // cdf_min = 100, divisor = 255: cdf 50 -> 0, 355 -> 255, 101 -> 1, 1000 -> saturate
  task automatic load_below_min();
    for (int i = 0; i < 256; i++) cdf_mem[i] = '0;
    cdf_mem[5] = 20'd50;
    cdf_mem[6] = 20'd355;
    cdf_mem[7] = 20'd101;
    cdf_mem[8] = 20'd1000;
    pix_mem[0] = {16{8'h05}};        exp_d[0] = {16{8'h00}};
    pix_mem[1] = {16{8'h06}};        exp_d[1] = {16{8'hFF}};
    pix_mem[2] = {16{8'h07}};        exp_d[2] = {16{8'h01}};
    pix_mem[3] = {8{8'h05, 8'h08}};  exp_d[3] = {8{8'h00, 8'hFF}};
    cdf_min = 20'd100;
    divisor = 20'd255;
  endtask

  task automatic test_below_min();
    load_below_min();
    do_run(1'b0, -1);
    checks++; if (n_wr != 4) begin errors++; $display("FAIL belowmin_wr_count: got %0d expected 4", n_wr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_d[i] !== exp_d[i]) begin errors++; $display("FAIL belowmin_wr_data[%0d]: got %h expected %h", i, wr_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_offset();
    load_below_min();
    do_run(1'b1, -1);
    checks++; if (done_cyc != LAT) begin errors++; $display("FAIL offset_latency: got %0d expected %0d", done_cyc, LAT); end
    checks++; if (n_wr != 4)       begin errors++; $display("FAIL offset_wr_count: got %0d expected 4", n_wr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_a[i] !== ADDR_W'(4 + i)) begin errors++; $display("FAIL offset_wr_addr[%0d]: got %0d expected %0d", i, wr_a[i], 4 + i); end
      checks++; if (wr_cyc[i] != 259 + i)      begin errors++; $display("FAIL offset_wr_cycle[%0d]: got %0d expected %0d", i, wr_cyc[i], 259 + i); end
      checks++; if (wr_d[i] !== exp_d[i])      begin errors++; $display("FAIL offset_wr_data[%0d]: got %h expected %h", i, wr_d[i], exp_d[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_restart();
    test_reset_mid();
    test_div_zero();
    test_below_min();
    test_offset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_eq_output_pipe.md
HIST_EQ_OUTPUT_PIPE -- requirements
Module: hist_eq_output_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16: 8-bit pixels per memory word, legal range 1..16.
REQ-002 SHALL have parameter NUM_WORDS, default 4096: pixel words per image.
REQ-003 SHALL have parameter ADDR_W, default 16: width of the memory address.
REQ-004 SHALL have parameter CDF_W, default 20: width of CDF entries, cdf_min and divisor.
REQ-005 Port: clock  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: reset_n  in  1  synchronous, active-low reset.
REQ-007 Port: start  in  1  begin a run; sampled in IDLE only.
REQ-008 Port: cdf_min, divisor  in  CDF_W each  equalisation constants; latched at start.
REQ-009 Port: output_base_offset  in  1  selects output bank; latched at start.
REQ-010 Port: cdf_addr  out  8  CDF memory read address; cdf_rdata  in  CDF_W  data valid the cycle after the address.
REQ-011 Port: pix_addr  out  ADDR_W  pixel read address; pix_rdata  in  LANES*8  data valid the cycle after the address.
REQ-012 Port: wr_en  out  1; wr_addr  out  ADDR_W; wr_data  out  LANES*8  output memory write port.
REQ-013 Port: busy  out  1  high outside IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, LUT_FILL, STREAM and DRAIN; start in IDLE moves to LUT_FILL, and start in any other state SHALL be ignored.
REQ-015 LUT_FILL SHALL drive cdf_addr 0..255 on 256 consecutive cycles, and SHALL write LUT entry i into an internal 256x8 register LUT on the cycle cdf_rdata for address i is valid.
REQ-016 Entry mapping: num = (cdf - cdf_min) * 255 at CDF_W+8 bits, with num = 0 when cdf < cdf_min; q = num / divisor, truncated.
REQ-017 The entry SHALL be min(q, 255); when divisor == 0 the entry SHALL be 255.
REQ-018 STREAM SHALL begin the cycle after LUT entry 255 is written.
REQ-019 STREAM SHALL issue pix_addr 0..NUM_WORDS-1 at one word per cycle, with no bubbles.
REQ-020 Each lane k (pix_rdata[8k+7:8k]) SHALL be mapped through the LUT into wr_data[8k+7:8k], all lanes in parallel.
REQ-021 A pixel word SHALL be written with wr_en high exactly 2 cycles after its pix_addr is presented.
REQ-022 wr_addr SHALL equal word index + (output_base_offset ? NUM_WORDS : 0), truncated to ADDR_W bits.
REQ-023 After the last pix_addr, the FSM SHALL enter DRAIN until the final write completes.
REQ-024 done SHALL pulse the cycle after the final write, and busy SHALL deassert in that same cycle (return to IDLE).
REQ-025 wr_en SHALL be low in IDLE and LUT_FILL, and SHALL never be high for more than NUM_WORDS cycles per run.
REQ-026 Total latency from the start edge to done SHALL be 256 + 1 + NUM_WORDS + 2 cycles.
REQ-027 A new run SHALL re-fill the LUT completely; LUT contents SHALL NOT be relied on across runs.

Reset
REQ-028 While reset_n is low at a clock edge: state = IDLE; busy, done, wr_en = 0; cdf_addr, pix_addr, wr_addr, wr_data = 0; latched constants = 0.
REQ-029 Reset asserted mid-run SHALL abort the run, with wr_en low from the next edge and no done pulse; LUT contents are don't-care.

Configuration
REQ-030 Macro HIST_EQ_ROUND_EN: when defined, q SHALL be (num + divisor/2) / divisor (round half up) before saturation; when undefined, q SHALL be truncated per REQ-016.
REQ-031 The divisor == 0 rule (REQ-017) SHALL apply identically with and without HIST_EQ_ROUND_EN.

Verification
REQ-032 Scenario: cdf[i] = i+1 for all i, cdf_min = 1, divisor = 63, LANES = 16, pixel word 0x00_20_3F repeated -> lanes map to 0x00, 0x81 (0x82 with HIST_EQ_ROUND_EN), 0xFF.
REQ-033 Scenario: divisor = 0, any CDF -> every written byte is 0xFF.
REQ-034 Scenario: cdf_min = 100, cdf[5] = 50, pixel 0x05 -> written byte 0x00.
REQ-035 Scenario: NUM_WORDS = 4, output_base_offset = 1 -> wr_addr 4,5,6,7 on consecutive cycles, and done 263 cycles after start.
REQ-036 Scenario: reset_n low for 1 cycle at STREAM word 2 -> wr_en low from the next edge, busy = 0, no done; a subsequent start completes normally.
REQ-037 Scenario: start re-pulsed during LUT_FILL -> cdf_addr sequence uninterrupted, and exactly one done pulse.
